// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair.
// Define HILO_SIGNED_MULDIV_EN to make ops MULT/DIV two's-complement.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             last_iter;
    logic             accept, mul_div_req, mt_req;

    logic [WIDTH-1:0] acc_hi, acc_lo, op_b;
    logic             is_div, dz;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign accept      = (state == IDLE) && bus.start;
    assign mul_div_req = accept && !bus.op[1];
    assign mt_req      = accept && (bus.op[2:1] == 2'b01);
    assign last_iter   = (count == CNT_W'(WIDTH - 1));
    assign bus.busy    = (state != IDLE);

`ifdef HILO_SIGNED_MULDIV_EN
    logic sign_a, sign_b, neg_res, neg_rem;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return WIDTH'(-x);
    endfunction

    assign sign_a = bus.op[2] & bus.operand_a[WIDTH-1];
    assign sign_b = bus.op[2] & bus.operand_b[WIDTH-1];
    assign a_mag  = sign_a ? negate(bus.operand_a) : bus.operand_a;
    assign b_mag  = sign_b ? negate(bus.operand_b) : bus.operand_b;

    always_ff @(posedge clk) begin
        if (mul_div_req) begin
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
        end
    end
`else
    assign a_mag = bus.operand_a;
    assign b_mag = bus.operand_b;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_div_req) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration step for each core; the latched op selects which one is kept.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, op_b};

    always_ff @(posedge clk) begin
        if (mul_div_req) begin
            acc_hi <= '0;
            acc_lo <= a_mag;
            op_b   <= b_mag;
            is_div <= bus.op[0];
            dz     <= bus.op[0] && (bus.operand_b == '0);
        end else if (state == RUN) begin
            if (!is_div) begin
                {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
                acc_hi <= div_diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi <= div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Magnitude results are sign-corrected only at commit time.
    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
`ifdef HILO_SIGNED_MULDIV_EN
        if (!is_div) begin
            if (neg_res) {res_hi, res_lo} = (2*WIDTH)'(-{acc_hi, acc_lo});
        end else begin
            if (neg_res) res_lo = negate(acc_lo);
            if (neg_rem) res_hi = negate(acc_hi);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            state           <= state_nxt;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            if (mul_div_req) count <= '0;
            else if (state == RUN) count <= count + CNT_W'(1);
            if (mt_req) begin
                if (bus.op[0]) bus.lo <= bus.operand_a;
                else bus.hi <= bus.operand_a;
                bus.done <= 1'b1;
            end
            if (state == FINISH) begin
                bus.done        <= 1'b1;
                bus.div_by_zero <= dz;
                if (!dz) begin
                    bus.hi <= res_hi;
                    bus.lo <= res_lo;
                end
            end
        end
    end
endmodule
